// File: rtl/chooser_pkg.sv
// Shared widths, the all-off LED value and the code-to-one-hot decode used by chooser_38.
package chooser_pkg;

  localparam int unsigned CODE_W = 3;
  localparam int unsigned LED_W  = 1 << CODE_W;

  localparam logic [LED_W-1:0] LED_ALL_OFF_H = 8'h00;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [LED_W-1:0]  led_t;

  // Unknown or X codes fall through to all-off rather than a stray LED.
  function automatic led_t code_to_onehot(input code_t code);
    led_t oh;
    case (code)
      3'd0:    oh = 8'h01;
      3'd1:    oh = 8'h02;
      3'd2:    oh = 8'h04;
      3'd3:    oh = 8'h08;
      3'd4:    oh = 8'h10;
      3'd5:    oh = 8'h20;
      3'd6:    oh = 8'h40;
      3'd7:    oh = 8'h80;
      default: oh = LED_ALL_OFF_H;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/decode_3to8.sv
// Purely combinational 3-to-8 one-hot decoder.
module decode_3to8
  import chooser_pkg::*;
(
  input  logic [CODE_W-1:0] codeIn,
  output logic [LED_W-1:0]  onehot
);

  always_comb begin
    onehot = code_to_onehot(codeIn);
  end

endmodule

// File: rtl/chooser_38.sv
// Registered 3-to-8 one-hot LED decoder with selectable output polarity.
module chooser_38
  import chooser_pkg::*;
#(
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] codeIn,
  output logic [LED_W-1:0]  ledOut
);

  localparam led_t LED_OFF = OUT_ACTIVE_LOW ? ~LED_ALL_OFF_H : LED_ALL_OFF_H;

  led_t onehot;
  led_t driveVal;

  decode_3to8 uDecode (
    .codeIn (codeIn),
    .onehot (onehot)
  );

  always_comb begin
    driveVal = OUT_ACTIVE_LOW ? ~onehot : onehot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ledOut <= LED_OFF;
    end else begin
      ledOut <= driveVal;
    end
  end

endmodule

// File: tb/tb_chooser_38.sv
// Bench for chooser_38: both polarities side by side against a one-cycle-delayed decode model.
module tb_chooser_38;

  logic       clk;
  logic       rst;
  logic [2:0] codeIn;
  logic [7:0] ledHi;
  logic [7:0] ledLo;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] expHi;
  logic [7:0] expLo;
  bit         modelValid = 1'b0;

  chooser_38 dutHi (
    .clk    (clk),
    .rst    (rst),
    .codeIn (codeIn),
    .ledOut (ledHi)
  );

  chooser_38 #(.OUT_ACTIVE_LOW(1'b1)) dutLo (
    .clk    (clk),
    .rst    (rst),
    .codeIn (codeIn),
    .ledOut (ledLo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the LED pattern is whatever the previous edge decoded.
  always @(posedge clk) begin
    if (rst) begin
      expHi      <= 8'h00;
      expLo      <= 8'hFF;
      modelValid <= 1'b1;
    end else if (modelValid) begin
      expHi <= 8'(1 << codeIn);
      expLo <= ~8'(1 << codeIn);
    end
  end

  always @(negedge clk) begin
    if (modelValid) begin
      check("model_hi", ledHi, expHi);
      check("model_lo", ledLo, expLo);
    end
  end

  task automatic tick(input logic r, input int c);
    rst    = r;
    codeIn = 3'(c);
    @(posedge clk);
    #2;
  endtask

  logic [7:0] sweepExp [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  int         streamCode [5] = '{7, 0, 3, 3, 5};
  logic [7:0] streamExp [5] = '{8'h80, 8'h01, 8'h08, 8'h08, 8'h20};

  initial begin
    rst    = 1'b1;
    codeIn = 3'b101;
    #2;
    tick(1'b1, 5);
    tick(1'b1, 5);
    check("reset_hi", ledHi, 8'h00);
    check("reset_lo", ledLo, 8'hFF);

    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 10; k++) begin
        tick(1'b0, c);
        if (k == 0) begin
          check("sweep_hi", ledHi, sweepExp[c]);
          check("sweep_lo", ledLo, ~sweepExp[c]);
        end
      end
    end

    tick(1'b0, 2);
    tick(1'b0, 2);
    check("latency_before", ledHi, 8'h04);
    codeIn = 3'b110;
    #1;
    check("latency_hold", ledHi, 8'h04);
    @(posedge clk);
    #2;
    check("latency_after", ledHi, 8'h40);

    for (int i = 0; i < 5; i++) begin
      tick(1'b0, streamCode[i]);
      check("stream_hi", ledHi, streamExp[i]);
    end

    tick(1'b0, 7);
    tick(1'b0, 7);
    check("midrst_pre", ledHi, 8'h80);
    tick(1'b1, 7);
    check("midrst_hi", ledHi, 8'h00);
    check("midrst_lo", ledLo, 8'hFF);
    tick(1'b0, 7);
    check("midrst_post", ledHi, 8'h80);

    tick(1'b0, 3);
    check("polarity_lo", ledLo, 8'hF7);
    check("polarity_hi", ledHi, 8'h08);
    tick(1'b1, 3);
    check("polarity_rst", ledLo, 8'hFF);

    tick(1'b0, 4);
    tick(1'b0, 1);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
